// File: rtl/checkpoint_seq_monitor.sv
// Watches a checkpoint bus for an ordered sequence of expected values, with a glitch filter and a per-step timeout.
// Optional feature macro: CKPT_STAMP_EN adds a 32-bit hit timestamp; otherwise hit_stamp is tied to 0.
module checkpoint_seq_monitor #(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 8,
  parameter int TIMEOUT_W  = 24,
  parameter int MIN_STABLE = 2
) (
  input  logic                       clock,
  input  logic                       resetb,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
  input  logic [DATA_W-1:0]          cfg_data,
  input  logic [$clog2(DEPTH):0]     seq_len,
  input  logic [TIMEOUT_W-1:0]       timeout_limit,
  input  logic                       arm,
  input  logic                       abort,
  input  logic [DATA_W-1:0]          obs,
  output logic                       busy,
  output logic                       step_hit,
  output logic [$clog2(DEPTH)-1:0]   step_idx,
  output logic                       pass,
  output logic                       fail,
  output logic [$clog2(DEPTH)-1:0]   fail_idx,
  output logic [31:0]                hit_stamp
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = $clog2(MIN_STABLE + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT      = 2'd1,
    DONE_PASS = 2'd2,
    DONE_FAIL = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [DATA_W-1:0]    obs_q;
  logic [DATA_W-1:0]    exp_mem [DEPTH];
  logic [LW-1:0]        len_q;
  logic [TIMEOUT_W-1:0] limit_q;
  logic [TIMEOUT_W-1:0] timer;
  logic [AW-1:0]        cur_idx;
  logic [AW-1:0]        hit_idx;
  logic [SW-1:0]        stable_cnt;

  logic                 arm_go;
  logic                 wait_run;
  logic                 match;
  logic                 hit;
  logic                 timeout;
  logic                 last_step;
  logic [LW-1:0]        len_clamped;
  logic [SW-1:0]        stable_nxt;
  logic [TIMEOUT_W-1:0] timer_nxt;

  assign arm_go      = arm && !abort && (state != WAIT);
  assign wait_run    = (state == WAIT) && !abort;
  assign len_clamped = (seq_len > LW'(DEPTH)) ? LW'(DEPTH) : seq_len;
  assign match       = (obs_q == exp_mem[cur_idx]);
  assign stable_nxt  = !match                          ? '0 :
                       (stable_cnt == SW'(MIN_STABLE)) ? stable_cnt :
                                                         stable_cnt + SW'(1);
  assign hit         = wait_run && (stable_nxt == SW'(MIN_STABLE));
  assign timer_nxt   = timer + TIMEOUT_W'(1);
  // A hit in the same cycle as the limit is reached takes priority over the timeout.
  assign timeout     = wait_run && (limit_q != '0) && (timer_nxt == limit_q) && !hit;
  assign last_step   = ({1'b0, cur_idx} == (len_q - LW'(1)));

  assign busy     = (state == WAIT);
  assign step_idx = step_hit ? hit_idx : cur_idx;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT: begin
        if (hit && last_step) begin
          state_nxt = DONE_PASS;
        end else if (timeout) begin
          state_nxt = DONE_FAIL;
        end
      end
      default: begin
        if (arm_go) begin
          state_nxt = (len_clamped == '0) ? DONE_PASS : WAIT;
        end
      end
    endcase
    if (abort) begin
      state_nxt = IDLE;
    end
  end

  // NOTE: the table is cleared by reset, so it is built from resettable flops rather than a RAM macro.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < DEPTH; i++) begin
        exp_mem[i] <= '0;
      end
    end else if (cfg_we && (state != WAIT)) begin
      exp_mem[cfg_addr] <= cfg_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      obs_q      <= '0;
      len_q      <= '0;
      limit_q    <= '0;
      timer      <= '0;
      cur_idx    <= '0;
      hit_idx    <= '0;
      stable_cnt <= '0;
      step_hit   <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      fail_idx   <= '0;
    end else begin
      obs_q    <= obs;
      step_hit <= 1'b0;
      if (abort) begin
        pass <= 1'b0;
        fail <= 1'b0;
      end else if (arm_go) begin
        len_q      <= len_clamped;
        limit_q    <= timeout_limit;
        timer      <= '0;
        cur_idx    <= '0;
        stable_cnt <= '0;
        fail       <= 1'b0;
        fail_idx   <= '0;
        pass       <= (len_clamped == '0);
      end else if (state == WAIT) begin
        if (hit) begin
          // The next step must collect a fresh run of matching samples, even for a repeated value.
          step_hit   <= 1'b1;
          hit_idx    <= cur_idx;
          cur_idx    <= cur_idx + AW'(1);
          stable_cnt <= '0;
          timer      <= '0;
          if (last_step) begin
            pass <= 1'b1;
          end
        end else begin
          stable_cnt <= stable_nxt;
          timer      <= timer_nxt;
          if (timeout) begin
            fail     <= 1'b1;
            fail_idx <= cur_idx;
          end
        end
      end
    end
  end

`ifdef CKPT_STAMP_EN
  logic [31:0] stamp_cnt;
  logic [31:0] stamp_inc;

  assign stamp_inc = (stamp_cnt == '1) ? stamp_cnt : stamp_cnt + 32'd1;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      stamp_cnt <= '0;
      hit_stamp <= '0;
    end else begin
      stamp_cnt <= arm_go ? '0 : stamp_inc;
      if (hit) begin
        hit_stamp <= stamp_inc;
      end
    end
  end
`else
  assign hit_stamp = '0;
`endif

endmodule
